bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter: accepts a packed multi-digit BCD number (default four digits, thousands/hundreds/tens/ones) and produces its unsigned binary value using reverse double-dabble, one bit per clock. It is the inverse of the team's binary-to-BCD display path. It sits between keypad/digit-entry logic and the arithmetic datapath, behind a start/done handshake.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bcd_to_bin_seq.sv | 98 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, defaults and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DefDigits = 4;
  localparam int unsigned DefBinW   = 14;

  function automatic logic digit_valid(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtract 3 from a post-shift digit of 8 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Valid BCD never exceeds 12 here, so the subtract cannot underflow.
  assign d_o = (d_i >= 4'd8) ? (d_i - 4'd3) : d_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter, one bit per clock, start/done handshake.
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = DefDigits,
  parameter int unsigned BIN_W  = DefBinW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  state_e           state_q;
  logic [BcdW-1:0]  bcd_q;
  logic [BcdW-1:0]  bcd_shift;
  logic [BcdW-1:0]  bcd_adj;
  logic [BIN_W-1:0] bin_q;
  logic [BIN_W-1:0] bin_next;
  logic [CntW-1:0]  cnt_q;
  logic             in_valid;

  always_comb begin
    in_valid = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!digit_valid(bcd_in[4*i +: 4])) in_valid = 1'b0;
    end
  end

  // {bcd, bin} shifted right as one word: bcd LSB falls into bin MSB.
  assign bcd_shift = bcd_q >> 1;
  assign bin_next  = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_shift[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      bin_out <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        // DONE accepts a new request exactly like IDLE for back-to-back use.
        StIdle, StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
          if (start) begin
            if (in_valid) begin
              bcd_q   <= bcd_in;
              bin_q   <= '0;
              cnt_q   <= '0;
              busy    <= 1'b1;
              state_q <= StShift;
            end else begin
              bin_out <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StShift: begin
          bcd_q <= bcd_adj;
          bin_q <= bin_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b0;
            bin_out <= bin_next;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq against a decimal-arithmetic reference model.
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        err;

  int total = 0;
  int bad = 0;

  bcd_to_bin_seq #(
    .DIGITS (4),
    .BIN_W  (14)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference: decimal value of the packed digits, and whether every digit is <= 9.
  function automatic int ref_val(input logic [15:0] b, output bit ok);
    int v = 0;
    int scale = 1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int d = int'(b[4*i +: 4]);
      if (d > 9) ok = 1'b0;
      v = v + d * scale;
      scale = scale * 10;
    end
    return ok ? v : 0;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; lat counts edges from the accepting edge (=1) to done.
  task automatic run_conv(input logic [15:0] b, output int lat, output int busy_cyc,
                          output logic [13:0] out, output logic e);
    start = 1'b1;
    bcd_in = b;
    step();
    start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      step();
      lat++;
    end
    out = bin_out;
    e = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, err, bin_out});
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_idle got=%b want=00", {busy, done});
    end
  endtask

  task automatic test_vectors();
    logic [15:0] vec [3] = '{16'h9999, 16'h1234, 16'h0000};
    int lat, bc, exp;
    bit ok;
    logic [13:0] out;
    logic e;
    foreach (vec[i]) begin
      exp = ref_val(vec[i], ok);
      run_conv(vec[i], lat, bc, out, e);
      total++;
      if (lat !== 15) begin
        bad++;
        $display("FAIL vec_latency bcd=%h got=%0d want=15", vec[i], lat);
      end
      total++;
      if (bc !== 14) begin
        bad++;
        $display("FAIL vec_busy_cycles bcd=%h got=%0d want=14", vec[i], bc);
      end
      total++;
      if (out !== 14'(exp) || e !== 1'b0) begin
        bad++;
        $display("FAIL vec_value bcd=%h got=%0d err=%b want=%0d err=0", vec[i], out, e, exp);
      end
      step();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL vec_done_pulse bcd=%h got=%b want=0", vec[i], done);
      end
    end
  endtask

  task automatic test_invalid();
    int lat, bc;
    logic [13:0] out;
    logic e;
    run_conv(16'h12A4, lat, bc, out, e);
    total++;
    if (lat !== 1 || bc !== 0) begin
      bad++;
      $display("FAIL invalid_latency got=%0d busy=%0d want=1 busy=0", lat, bc);
    end
    total++;
    if (e !== 1'b1 || out !== 14'd0) begin
      bad++;
      $display("FAIL invalid_result got=%0d err=%b want=0 err=1", out, e);
    end
    step();
    run_conv(16'h0042, lat, bc, out, e);
    total++;
    if (e !== 1'b0 || out !== 14'd42 || lat !== 15) begin
      bad++;
      $display("FAIL after_invalid got=%0d err=%b lat=%0d want=42 err=0 lat=15", out, e, lat);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    logic [13:0] out;
    logic e;
    start = 1'b1;
    bcd_in = 16'h0007;
    step();
    start = 1'b0;
    lat = 1;
    repeat (3) begin step(); lat++; end
    start = 1'b1;
    bcd_in = 16'h5555;
    repeat (2) begin step(); lat++; end
    start = 1'b0;
    while (!done && lat < 40) begin step(); lat++; end
    total++;
    if (lat !== 15 || bin_out !== 14'd7 || err !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start got=%0d lat=%0d want=7 lat=15", bin_out, lat);
    end
    // Request issued during the DONE cycle must be taken immediately.
    run_conv(16'h0100, lat, bc, out, e);
    total++;
    if (lat !== 15 || out !== 14'd100 || e !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done got=%0d lat=%0d want=100 lat=15", out, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    logic [13:0] out;
    logic e;
    start = 1'b1;
    bcd_in = 16'h9999;
    step();
    start = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    total++;
    if ({busy, done, err, bin_out} !== 17'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, err, bin_out});
    end
    seen = 0;
    repeat (20) begin
      if (done || busy) seen++;
      step();
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_aborted got=%0d active cycles want=0", seen);
    end
    run_conv(16'h8765, lat, bc, out, e);
    total++;
    if (out !== 14'h223D || e !== 1'b0 || lat !== 15) begin
      bad++;
      $display("FAIL reset_mid_next got=%h lat=%0d want=223d lat=15", out, lat);
    end
    step();
  endtask

  task automatic test_random();
    int lat, bc, exp;
    bit ok;
    logic [13:0] out;
    logic e;
    logic [15:0] b;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(3) == 0) b = 16'($urandom);
      else b = to_bcd(int'($urandom_range(9999)));
      exp = ref_val(b, ok);
      run_conv(b, lat, bc, out, e);
      total++;
      if (out !== 14'(exp) || e !== !ok || lat !== (ok ? 15 : 1)) begin
        bad++;
        $display("FAIL random bcd=%h got=%0d err=%b lat=%0d want=%0d err=%b", b, out, e, lat,
                 exp, !ok);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bc, errs;
    logic [13:0] out;
    logic e;
    errs = 0;
    for (int v = 0; v <= 9999; v += 7) begin
      run_conv(to_bcd(v), lat, bc, out, e);
      if (out !== 14'(v) || e !== 1'b0 || lat !== 15) begin
        errs++;
        if (errs <= 5) $display("FAIL sweep v=%0d got=%0d err=%b lat=%0d", v, out, e, lat);
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL sweep_total got=%0d wrong want=0", errs);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_invalid();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
